// File: rtl/dpram_36x1024.sv
// dpram_36x1024: 1024x36 dual-port RAM, two reads and two writes per clock, registered read data.
// Macro DPRAM_36X1024_WR_FWD_EN selects write-first read-during-write; default is read-first.
`default_nettype none

module dpram_36x1024 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  REN1_i,
  input  logic [ADDR_WIDTH-1:0] RD1_ADDR_i,
  output logic [DATA_WIDTH-1:0] RDATA1_o,
  input  logic                  WEN1_i,
  input  logic [ADDR_WIDTH-1:0] WR1_ADDR_i,
  input  logic [DATA_WIDTH-1:0] WDATA1_i,
  input  logic                  REN2_i,
  input  logic [ADDR_WIDTH-1:0] RD2_ADDR_i,
  output logic [DATA_WIDTH-1:0] RDATA2_o,
  input  logic                  WEN2_i,
  input  logic [ADDR_WIDTH-1:0] WR2_ADDR_i,
  input  logic [DATA_WIDTH-1:0] WDATA2_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_val;
  logic [DATA_WIDTH-1:0] rd2_val;

  // Memory has no reset; port 2 is written last so it wins an address collision.
  always_ff @(posedge clock0) begin
    if (WEN1_i) mem[WR1_ADDR_i] <= WDATA1_i;
    if (WEN2_i) mem[WR2_ADDR_i] <= WDATA2_i;
  end

`ifdef DPRAM_36X1024_WR_FWD_EN
  always_comb begin
    rd1_val = mem[RD1_ADDR_i];
    if (WEN2_i && (WR2_ADDR_i == RD1_ADDR_i))      rd1_val = WDATA2_i;
    else if (WEN1_i && (WR1_ADDR_i == RD1_ADDR_i)) rd1_val = WDATA1_i;
  end

  always_comb begin
    rd2_val = mem[RD2_ADDR_i];
    if (WEN2_i && (WR2_ADDR_i == RD2_ADDR_i))      rd2_val = WDATA2_i;
    else if (WEN1_i && (WR1_ADDR_i == RD2_ADDR_i)) rd2_val = WDATA1_i;
  end
`else
  always_comb begin
    rd1_val = mem[RD1_ADDR_i];
    rd2_val = mem[RD2_ADDR_i];
  end
`endif

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      RDATA1_o <= '0;
      RDATA2_o <= '0;
    end else begin
      if (REN1_i) RDATA1_o <= rd1_val;
      if (REN2_i) RDATA2_o <= rd2_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpram_36x1024.sv
// Scoreboard bench for dpram_36x1024: driver predicts reads from an array model, monitor checks outputs.
`default_nettype none

module tb_dpram_36x1024;

  localparam int AW = 10;
  localparam int DW = 36;
`ifdef DPRAM_36X1024_WR_FWD_EN
  localparam logic [DW-1:0] EXP_RDW = 36'h123456789;
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam logic [DW-1:0] EXP_RDW = 36'hAAAAAAAAA;
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic          clock0 = 1'b0;
  logic          reset  = 1'b1;
  logic          REN1_i = 1'b0, WEN1_i = 1'b0, REN2_i = 1'b0, WEN2_i = 1'b0;
  logic [AW-1:0] RD1_ADDR_i = '0, WR1_ADDR_i = '0, RD2_ADDR_i = '0, WR2_ADDR_i = '0;
  logic [DW-1:0] WDATA1_i = '0, WDATA2_i = '0;
  logic [DW-1:0] RDATA1_o, RDATA2_o;

  dpram_36x1024 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock0(clock0), .reset(reset),
    .REN1_i(REN1_i), .RD1_ADDR_i(RD1_ADDR_i), .RDATA1_o(RDATA1_o),
    .WEN1_i(WEN1_i), .WR1_ADDR_i(WR1_ADDR_i), .WDATA1_i(WDATA1_i),
    .REN2_i(REN2_i), .RD2_ADDR_i(RD2_ADDR_i), .RDATA2_o(RDATA2_o),
    .WEN2_i(WEN2_i), .WR2_ADDR_i(WR2_ADDR_i), .WDATA2_i(WDATA2_i)
  );

  always #5 clock0 = ~clock0;

  logic [DW-1:0] model [1024];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] d_of(input int a);
    logic [DW-1:0] v;
    v = DW'(a) | (DW'(a) << 20) | 36'h55000;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read of address ra would return this cycle, given the writes happening alongside it.
  function automatic logic [DW-1:0] predict(input int ra, input bit w1, input int wa1, input logic [DW-1:0] wd1,
                                            input bit w2, input int wa2, input logic [DW-1:0] wd2);
    if (WRITE_FIRST && w2 && wa2 == ra) return wd2;
    if (WRITE_FIRST && w1 && wa1 == ra) return wd1;
    return model[ra];
  endfunction

  task automatic step(input bit rst_v,
                      input bit r1, input int ra1, input bit w1, input int wa1, input logic [DW-1:0] wd1,
                      input bit r2, input int ra2, input bit w2, input int wa2, input logic [DW-1:0] wd2,
                      input bit use_c1 = 1'b0, input logic [DW-1:0] c1 = '0,
                      input bit use_c2 = 1'b0, input logic [DW-1:0] c2 = '0);
    @(negedge clock0);
    reset = rst_v;
    REN1_i = r1; RD1_ADDR_i = AW'(ra1); WEN1_i = w1; WR1_ADDR_i = AW'(wa1); WDATA1_i = wd1;
    REN2_i = r2; RD2_ADDR_i = AW'(ra2); WEN2_i = w2; WR2_ADDR_i = AW'(wa2); WDATA2_i = wd2;
    if (r1 && !rst_v) q1.push_back(use_c1 ? c1 : predict(ra1, w1, wa1, wd1, w2, wa2, wd2));
    if (r2 && !rst_v) q2.push_back(use_c2 ? c2 : predict(ra2, w1, wa1, wd1, w2, wa2, wd2));
    if (w1) model[wa1] = wd1;
    if (w2) model[wa2] = wd2;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  // Monitor: a read issued at an edge is due just after that edge; otherwise outputs must hold.
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  always @(posedge clock0) begin
    bit p1, p2;
    p1 = REN1_i && !reset;
    p2 = REN2_i && !reset;
    #1;
    if (reset) begin
      last1 = '0;
      last2 = '0;
    end else begin
      if (p1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL port1_queue: read seen with no expected entry at %0t", $time);
        end else last1 = q1.pop_front();
      end
      if (p2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL port2_queue: read seen with no expected entry at %0t", $time);
        end else last2 = q2.pop_front();
      end
    end
    chk("rdata1", RDATA1_o, last1);
    chk("rdata2", RDATA2_o, last2);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_rdata1", RDATA1_o, '0);
    chk("reset_rdata2", RDATA2_o, '0);

    // Concurrent fill: port 1 low half, port 2 high half.
    for (int a = 0; a < 512; a++)
      step(1'b0, 0, 0, 1, a, d_of(a), 0, 0, 1, a + 512, d_of(a + 512));
    step(1'b0, 1, 3, 0, 0, '0, 1, 600, 0, 0, '0, 1'b1, 36'h000355003, 1'b1, 36'h025855258);

    // Full read sweep on both ports, with a reset pulse in the middle.
    for (int a = 0; a < 1024; a++) begin
      if (a == 300) begin
        @(posedge clock0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_rdata1", RDATA1_o, '0);
        chk("async_reset_rdata2", RDATA2_o, '0);
        step(1'b1, 1, 4, 1, 20, 36'hABCDE1234, 1, 5, 0, 0, '0);
        step(1'b1, 1, 6, 0, 0, '0, 1, 7, 0, 0, '0);
        step(1'b0, 1, 3, 0, 0, '0, 1, 20, 0, 0, '0, 1'b1, 36'h000355003, 1'b1, 36'hABCDE1234);
      end
      step(1'b0, 1, a, 0, 0, '0, 1, 1023 - a, 0, 0, '0);
    end

    // Read address 5, then hold with enable low while the address moves.
    step(1'b0, 1, 5, 0, 0, '0, 0, 0, 0, 0, '0, 1'b1, 36'h000555005);
    for (int i = 0; i < 4; i++)
      step(1'b0, 0, $urandom_range(1023, 0), 0, 0, '0, 0, $urandom_range(1023, 0), 0, 0, '0);

    // Same-address double write, then both ports read it.
    step(1'b0, 0, 0, 1, 7, 36'h111111111, 0, 0, 1, 7, 36'h222222222);
    step(1'b0, 1, 7, 0, 0, '0, 1, 7, 0, 0, '0, 1'b1, 36'h222222222, 1'b1, 36'h222222222);

    // Read-during-write on address 9.
    step(1'b0, 0, 0, 1, 9, 36'hAAAAAAAAA, 0, 0, 0, 0, '0);
    step(1'b0, 0, 0, 1, 9, 36'h123456789, 1, 9, 0, 0, '0, 1'b0, '0, 1'b1, EXP_RDW);
    step(1'b0, 1, 9, 0, 0, '0, 1, 9, 0, 0, '0, 1'b1, 36'h123456789, 1'b1, 36'h123456789);

    // Random traffic over a narrow address window to force collisions.
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom), $urandom_range(15, 0), 1'($urandom), $urandom_range(15, 0), rnd_data(),
           1'($urandom), $urandom_range(15, 0), 1'($urandom), $urandom_range(15, 0), rnd_data());

    idle();
    idle();
    @(negedge clock0);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: q1=%0d q2=%0d, expected 0 and 0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
